// File: rtl/vlog_gear_plant.sv
// Landing-gear hydraulics and takeoff-timer plant model (controller responder).
// Define GEAR_JAM_EN to add the Jam input that freezes gear travel.
module vlog_gear_plant #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int TIMEUP_CYCLES = 100,
  parameter int POS_W = $clog2(TRAVEL_CYCLES + 1),
  parameter int TMR_W = $clog2(TIMEUP_CYCLES + 1)
) (
  input  logic             Clock,
  input  logic             Clear_n,
  input  logic             Valve,
  input  logic             Pump,
  input  logic             Timer,
`ifdef GEAR_JAM_EN
  input  logic             Jam,
`endif
  output logic             GearIsDown,
  output logic             GearIsUp,
  output logic             TimeUp,
  output logic [POS_W-1:0] GearPos
);

  typedef enum logic [2:0] {
    DNLK,
    MOVUP,
    MOVDN,
    HALT,
    UPLK
  } state_t;

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(TIMEUP_CYCLES);

  state_t           state;
  state_t           nstate;
  logic [POS_W-1:0] npos;
  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] ncnt;
  logic             up_cmd;
  logic             dn_cmd;
  logic             jam;

`ifdef GEAR_JAM_EN
  assign jam = Jam;
`else
  assign jam = 1'b0;
`endif

  assign up_cmd = Pump && !Valve;
  assign dn_cmd = Pump && Valve;

  always_comb begin
    nstate = state;
    npos   = GearPos;
    unique case (state)
      DNLK: begin
        if (up_cmd && !jam) begin
          nstate = MOVUP;
          npos   = POS_ONE;
        end
      end
      UPLK: begin
        if (dn_cmd && !jam) begin
          nstate = MOVDN;
          npos   = POS_TOP - POS_ONE;
        end
      end
      default: begin
        // in transit: a jam freezes both position and state
        if (!jam) begin
          if (up_cmd) begin
            npos   = GearPos + POS_ONE;
            nstate = (npos == POS_TOP) ? UPLK : MOVUP;
          end else if (dn_cmd) begin
            npos   = GearPos - POS_ONE;
            nstate = (npos == '0) ? DNLK : MOVDN;
          end else begin
            nstate = HALT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state      <= DNLK;
      GearPos    <= '0;
      GearIsDown <= 1'b1;
      GearIsUp   <= 1'b0;
    end else begin
      state      <= nstate;
      GearPos    <= npos;
      GearIsDown <= (nstate == DNLK);
      GearIsUp   <= (nstate == UPLK);
    end
  end

  always_comb begin
    ncnt = cnt;
    if (Timer) begin
      ncnt = '0;
    end else if (cnt != TMR_TOP) begin
      ncnt = cnt + TMR_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      cnt    <= '0;
      TimeUp <= 1'b0;
    end else begin
      cnt    <= ncnt;
      TimeUp <= (ncnt == TMR_TOP);
    end
  end

endmodule

// File: tb/tb_vlog_gear_plant.sv
// Directed bench for vlog_gear_plant, TRAVEL_CYCLES=8, TIMEUP_CYCLES=5.
// Define GEAR_JAM_EN to also exercise the jam feature.
module tb_vlog_gear_plant;

  localparam int TRAVEL = 8;
  localparam int TIMEUP = 5;
  localparam int POS_W  = $clog2(TRAVEL + 1);
  localparam int TMR_W  = $clog2(TIMEUP + 1);

  logic             Clock;
  logic             Clear_n;
  logic             Valve;
  logic             Pump;
  logic             Timer;
  logic             GearIsDown;
  logic             GearIsUp;
  logic             TimeUp;
  logic [POS_W-1:0] GearPos;
`ifdef GEAR_JAM_EN
  logic             Jam;
`endif

  int n_chk;
  int n_err;

  vlog_gear_plant #(
    .TRAVEL_CYCLES(TRAVEL),
    .TIMEUP_CYCLES(TIMEUP),
    .POS_W(POS_W),
    .TMR_W(TMR_W)
  ) dut (
    .Clock(Clock),
    .Clear_n(Clear_n),
    .Valve(Valve),
    .Pump(Pump),
    .Timer(Timer),
`ifdef GEAR_JAM_EN
    .Jam(Jam),
`endif
    .GearIsDown(GearIsDown),
    .GearIsUp(GearIsUp),
    .TimeUp(TimeUp),
    .GearPos(GearPos)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_gear(input string tag, input int pos,
                          input int dn, input int up);
    chk({tag, ".pos"}, int'(GearPos), pos);
    chk({tag, ".dn"}, int'(GearIsDown), dn);
    chk({tag, ".up"}, int'(GearIsUp), up);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    Clear_n = 1'b0;
    Valve   = 1'b0;
    Pump    = 1'b0;
    Timer   = 1'b1;
`ifdef GEAR_JAM_EN
    Jam     = 1'b0;
`endif
    #12;
    chk_gear("rst", 0, 1, 0);
    chk("rst.tup", int'(TimeUp), 0);
    tick();
    Clear_n = 1'b1;
    tick();
    chk_gear("idle", 0, 1, 0);

    // full retract
    Pump  = 1'b1;
    Valve = 1'b0;
    for (int i = 1; i <= TRAVEL; i++) begin
      tick();
      chk_gear("retract", i, 0, (i == TRAVEL) ? 1 : 0);
    end

    // pumping toward the locked side does nothing
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_gear("uplk_noop", TRAVEL, 0, 1);
    end

    // full extend
    Valve = 1'b1;
    for (int i = 1; i <= TRAVEL; i++) begin
      tick();
      chk_gear("extend", TRAVEL - i, (i == TRAVEL) ? 1 : 0, 0);
    end

    // halt and reversal
    Valve = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_gear("hr_up", i, 0, 0);
    end
    Pump = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_gear("hr_halt", 3, 0, 0);
    end
    Pump  = 1'b1;
    Valve = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_gear("hr_dn", 3 - i, (i == 3) ? 1 : 0, 0);
    end
    Pump = 1'b0;

    // timer
    Timer = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("tmr_cnt", int'(TimeUp), (i >= TIMEUP) ? 1 : 0);
    end
    Timer = 1'b1;
    tick();
    chk("tmr_clr", int'(TimeUp), 0);
    Timer = 1'b0;
    tick();
    chk("tmr_restart", int'(TimeUp), 0);
    chk_gear("tmr_gear", 0, 1, 0);

    // async reset mid-travel and mid-count
    Timer = 1'b1;
    tick();
    Timer = 1'b0;
    tick();
    Pump  = 1'b1;
    Valve = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_gear("pre_rst", 4, 0, 0);
    chk("pre_rst.tup", int'(TimeUp), 1);
    #2;
    Clear_n = 1'b0;
    #1;
    chk_gear("mid_rst", 0, 1, 0);
    chk("mid_rst.tup", int'(TimeUp), 0);
    Pump  = 1'b0;
    Timer = 1'b1;
    tick();
    chk_gear("rst_hold", 0, 1, 0);
    Clear_n = 1'b1;
    tick();

`ifdef GEAR_JAM_EN
    Pump  = 1'b1;
    Valve = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_gear("jam_pre", 5, 0, 0);
    Jam = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_gear("jam_hold", 5, 0, 0);
    end
    Jam = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_gear("jam_rel", 5 + i, 0, (i == 3) ? 1 : 0);
    end
    Jam   = 1'b1;
    Valve = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gear("jam_lock", TRAVEL, 0, 1);
    end
    Jam = 1'b0;
    tick();
    chk_gear("jam_unlock", TRAVEL - 1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vlog_gear_plant.md
# vlog_gear_plant

Behavioural plant model for the landing-gear hydraulics and takeoff timer: the responder side of the gear controller interface. It consumes the controller's Valve, Pump and Timer commands and returns GearIsDown, GearIsUp and TimeUp, closing the loop so the controller FSM can be simulated and verified cycle-accurately. It sits in the testbench/emulation layer beside the controller and is synthesizable for FPGA-in-the-loop use.

## Interface
- TRAVEL_CYCLES, 16: clock edges of continuous pumping needed to move the gear fully between locks; legal range ≥2.
- TIMEUP_CYCLES, 100: clock edges of Timer=COUNT before TimeUp asserts; legal range ≥1.
- POS_W, $clog2(TRAVEL_CYCLES+1): width of the position counter.
- TMR_W, $clog2(TIMEUP_CYCLES+1): width of the timer counter.

- Clock  input  1  system clock, rising edge.
- Clear_n  input  1  asynchronous active-low reset.
- Valve  input  1  1=DOWN, 0=UP direction command.
- Pump  input  1  1=ON; the gear moves only while the pump is on.
- Timer  input  1  1=RESET (clear timer), 0=COUNT.
- GearIsDown  output  1  gear down and locked.
- GearIsUp  output  1  gear up and locked.
- TimeUp  output  1  takeoff timer expired.
- GearPos  output  POS_W  current position; 0=down, TRAVEL_CYCLES=up.
- Jam  input  1  present only with GEAR_JAM_EN; see Configuration.

## Operation
- States: DNLK (down locked), MOVUP, MOVDN, HALT (in transit, pump off), UPLK (up locked).
- All outputs registered. GearIsDown=(state==DNLK); GearIsUp=(state==UPLK); never both 1.
- Define up_cmd=Pump&&!Valve and dn_cmd=Pump&&Valve.
- DNLK: up_cmd → MOVUP, pos←1. Otherwise hold.
- UPLK: dn_cmd → MOVDN, pos←TRAVEL_CYCLES−1. Otherwise hold.
- MOVUP / MOVDN / HALT, evaluated each edge:
  - up_cmd: pos←pos+1; the next state is UPLK if the new pos is TRAVEL_CYCLES, else MOVUP.
  - dn_cmd: pos←pos−1; the next state is DNLK if the new pos is 0, else MOVDN.
  - !Pump: HALT, pos held.
- Reversal mid-travel takes effect on the same edge, with no dead cycle.
- Timer: Timer=1 clears the count to 0 and drives TimeUp to 0 on the next edge. Timer=0 increments the count, saturating at TIMEUP_CYCLES. TimeUp=(count==TIMEUP_CYCLES).
- The timer path and the gear path are independent.

## Timing
- Reset (asynchronous, Clear_n=0): state=DNLK, GearPos=0, GearIsDown=1, GearIsUp=0, timer count=0, TimeUp=0.
- Reset mid-travel or mid-count forces these values immediately, regardless of the clock.
- Outputs update only on Clock rising edges after Clear_n deasserts.
- Full retract latency from DNLK: GearIsDown falls at edge 1 of up_cmd. GearIsUp rises at edge TRAVEL_CYCLES, provided up_cmd is held continuously.
- Full extend latency from UPLK: symmetric.
- Pump-off edges add latency one-for-one.
- TimeUp latency: rises at the TIMEUP_CYCLES-th consecutive edge with Timer=0. It stays 1 until an edge with Timer=1.
- Boundary behaviour:
  - Pump on with Valve matching the locked side: no movement, no output change.
  - GearPos never leaves [0, TRAVEL_CYCLES].
  - The timer count never wraps.

## Configuration
- GEAR_JAM_EN defined:
  - Adds input Jam.
  - While Jam=1 in MOVUP/MOVDN/HALT, pos and state are frozen, even with Pump on.
  - A locked gear may not unlock while Jam=1.
  - Jam has no effect on the timer.
- GEAR_JAM_EN undefined: no Jam port, and the gear always moves as commanded.

## Test plan
Parameters for all scenarios: TRAVEL_CYCLES=8, TIMEUP_CYCLES=5.
- Reset: assert Clear_n=0 asynchronously mid-travel at pos=4 → outputs immediately return to GearPos=0, GearIsDown=1, GearIsUp=0, TimeUp=0.
- Full retract: Pump=1, Valve=0 held from DNLK → GearIsDown=0 at edge 1, GearPos=1..8, GearIsUp=1 at edge 8, never both high.
- Halt and reversal: retract 3 edges, Pump=0 for 4 edges (GearPos stays 3), then Pump=1, Valve=1 → GearPos 2,1,0 and GearIsDown=1 at the 3rd pumped edge.
- Timer: Timer=0 for 5 edges → TimeUp=1 at edge 5 and holds through edge 10. Timer=1 for one edge → TimeUp=0 next edge.
- Locked no-op: in UPLK with Pump=1, Valve=0 for 20 edges → GearIsUp stays 1 and GearPos stays 8.
- GEAR_JAM_EN build: Jam=1 at GearPos=5 during retract → GearPos stays 5 for 10 edges. Release Jam → GearIsUp=1 three edges later.
